// File: rtl/la_trigger_capture.sv
// Logic-analyzer trigger/capture: circular pre-trigger history, post count, oldest-first readout.
// Optional LA_EXT_TRIG_EN adds an ext_trig input whose rising edge also triggers.
module la_trigger_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] din,
  input  logic [15:0]       sample_div,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [ADDR_W-1:0] pre_depth,
  input  logic              arm,
`ifdef LA_EXT_TRIG_EN
  input  logic              ext_trig,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ONE = 1;
  localparam logic [ADDR_W:0] RD_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READ
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       div_q, div_d;
  logic [15:0]       sdiv_q, sdiv_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              p_valid_q, p_valid_d;
  logic              p_last_q, p_last_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              head_last_q, head_last_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              skid_last_q, skid_last_d;
  logic [1:0]        occ_q, occ_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  logic              capturing;
  logic              strobe;
  logic              match;
  logic              trig_hit;
  logic              arm_go;
  logic              pop;
  logic              last_pop;
  logic              issue;
  logic [1:0]        inflight;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] rd_addr;

  assign capturing = (state_q == PRE) || (state_q == WAIT_TRIG)
                  || (state_q == POST);
  assign strobe    = capturing && (div_q == sdiv_q);
  assign match     = ((din ^ value_q) & mask_q) == '0;
  assign arm_go    = (state_q == IDLE) && arm;
  assign cnt_inc   = cnt_q + ONE;
  assign rd_addr   = wr_ptr_q + rd_cnt_q[ADDR_W-1:0];

  assign rd_valid  = occ_q != 2'd0;
  assign rd_data   = head_q;
  assign rd_last   = rd_valid && head_last_q;
  assign done      = done_q;
  assign pop       = rd_valid && rd_ready;
  assign last_pop  = pop && head_last_q;

  // Credit check: entries held plus the one in the RAM stage must fit the 2-deep buffer.
  assign inflight  = occ_q + {1'b0, p_valid_q};
  assign issue     = (state_q == READ) && !rd_cnt_q[ADDR_W]
                  && ((inflight < 2'd2) || ((inflight == 2'd2) && pop));

`ifdef LA_EXT_TRIG_EN
  logic ext_q, ext_prev_q;
  logic pend_q, pend_d;
  logic ext_rise;

  assign ext_rise = ext_q && !ext_prev_q;
  assign trig_hit = match || pend_q || ext_rise;

  always_comb begin
    pend_d = pend_q || ext_rise;
    if (arm_go || strobe) pend_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ext_q      <= 1'b0;
      ext_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      ext_q      <= ext_trig;
      ext_prev_q <= ext_q;
      pend_q     <= pend_d;
    end
  end
`else
  assign trig_hit = match;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = (pre_depth == '0) ? WAIT_TRIG : PRE;
      end
      PRE: begin
        if (strobe && (cnt_inc == pre_q)) state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (strobe && trig_hit) state_d = (pre_q == '1) ? READ : POST;
      end
      POST: begin
        if (strobe && (cnt_q == ONE)) state_d = READ;
      end
      READ: begin
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = state_q != IDLE;
  end

  always_comb begin
    div_d       = div_q;
    sdiv_d      = sdiv_q;
    pre_d       = pre_q;
    mask_d      = mask_q;
    value_d     = value_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    rd_cnt_d    = rd_cnt_q;
    p_valid_d   = issue;
    p_last_d    = issue && (rd_cnt_q[ADDR_W-1:0] == '1);
    head_d      = head_q;
    head_last_d = head_last_q;
    skid_d      = skid_q;
    skid_last_d = skid_last_q;
    occ_d       = occ_q;

    if (arm_go) begin
      sdiv_d   = sample_div;
      pre_d    = pre_depth;
      mask_d   = trig_mask;
      value_d  = trig_value;
      div_d    = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      rd_cnt_d = '0;
      done_d   = 1'b0;
    end

    if (capturing) div_d = strobe ? '0 : div_q + 16'd1;
    if (strobe) wr_ptr_d = wr_ptr_q + ONE;

    // cnt_q counts pre samples, then the post samples still owed.
    if (strobe) begin
      if (state_q == PRE) begin
        cnt_d = (cnt_inc == pre_q) ? '0 : cnt_inc;
      end else if (state_q == WAIT_TRIG && trig_hit) begin
        cnt_d = ~pre_q;
      end else if (state_q == POST) begin
        cnt_d = cnt_q - ONE;
      end
    end

    if (issue) rd_cnt_d = rd_cnt_q + RD_ONE;

    case (occ_q)
      2'd0: begin
        if (p_valid_q) begin
          head_d      = ram_rd_q;
          head_last_d = p_last_q;
          occ_d       = 2'd1;
        end
      end
      2'd1: begin
        if (p_valid_q && pop) begin
          head_d      = ram_rd_q;
          head_last_d = p_last_q;
        end else if (p_valid_q) begin
          skid_d      = ram_rd_q;
          skid_last_d = p_last_q;
          occ_d       = 2'd2;
        end else if (pop) begin
          occ_d       = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d      = skid_q;
          head_last_d = skid_last_q;
          occ_d       = 2'd1;
        end
      end
    endcase

    if (last_pop) begin
      occ_d     = 2'd0;
      p_valid_d = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_q       <= '0;
      sdiv_q      <= '0;
      pre_q       <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rd_cnt_q    <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      head_q      <= '0;
      head_last_q <= 1'b0;
      skid_q      <= '0;
      skid_last_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      div_q       <= div_d;
      sdiv_q      <= sdiv_d;
      pre_q       <= pre_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rd_cnt_q    <= rd_cnt_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      head_q      <= head_d;
      head_last_q <= head_last_d;
      skid_q      <= skid_d;
      skid_last_q <= skid_last_d;
      occ_q       <= occ_d;
    end
  end

  // Sample RAM: contents are deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (strobe) mem_q[wr_ptr_q] <= din;
    if (issue)  ram_rd_q <= mem_q[rd_addr];
  end

endmodule

// File: tb/tb_la_trigger_capture.sv
// Bench for la_trigger_capture (ADDR_W=4): table of capture setups
// checked against a sample-index reference model.
module tb_la_trigger_capture;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NV    = 14;
  localparam int NRND  = 4096;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [DW-1:0] din;
  logic [15:0]   sample_div;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic [AW-1:0] pre_depth;
  logic          arm;
  logic          busy;
  logic          done;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
`ifdef LA_EXT_TRIG_EN
  logic          ext_trig = 1'b0;
`endif

  la_trigger_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .din        (din),
    .sample_div (sample_div),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .pre_depth  (pre_depth),
    .arm        (arm),
`ifdef LA_EXT_TRIG_EN
    .ext_trig   (ext_trig),
`endif
    .busy       (busy),
    .done       (done),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          sdiv;
    logic [7:0]  mask;
    logic [7:0]  value;
    int          pre;
    int          mode;
    int          rdy;
    int          glitch;
    int          chk;
    logic [7:0]  exp_trig;
  } vec_t;

  vec_t       vecs [NV];
  logic [7:0] rnd [NRND];
  logic [7:0] exp_win [DEPTH];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // din driven during cycle c after the arm edge
  function automatic logic [7:0] din_at(input int mode, input int c);
    logic [7:0] v;
    int r;
    v = 8'h88;
    if (mode == 0) return c[7:0];
    if (mode == 1) begin
      r = (c / 1000) % 8;
      return (v << r) | (v >> (8 - r));
    end
    return (c < NRND) ? rnd[c] : 8'h00;
  endfunction

  // Sample k is taken in cycle k*(sdiv+1)+sdiv; window starts pre samples before trigger.
  task automatic model(input vec_t v, output int cf, output bit ok);
    int t;
    int per;
    logic [7:0] s;
    per = v.sdiv + 1;
    ok = 1'b0;
    t = 0;
    for (int k = v.pre; k < 5000; k++) begin
      s = din_at(v.mode, k * per + v.sdiv);
      if (((s ^ v.value) & v.mask) == 8'h00) begin
        t = k;
        ok = 1'b1;
        break;
      end
    end
    for (int i = 0; i < DEPTH; i++)
      exp_win[i] = din_at(v.mode, (t - v.pre + i) * per + v.sdiv);
    cf = (t - v.pre + DEPTH - 1) * per + v.sdiv;
  endtask

  task automatic arm_cfg(input vec_t v);
    @(posedge sys_clk); #1;
    sample_div = 16'(v.sdiv);
    trig_mask  = v.mask;
    trig_value = v.value;
    pre_depth  = 4'(v.pre);
    arm        = 1'b1;
    @(posedge sys_clk); #1;
    arm = 1'b0;
    din = din_at(v.mode, 0);
    chk("busy after arm", 32'(busy), 32'd1);
    chk("done cleared by arm", 32'(done), 32'd0);
  endtask

  task automatic run_cap(input int vi);
    vec_t v;
    int cf, c, nb, first, limit;
    bit ok, stall;
    logic [7:0] pd;
    logic pl;
    v = vecs[vi];
    model(v, cf, ok);
    if (!ok) return;
    arm_cfg(v);
    rd_ready = (v.rdy != 0) ? 1'($urandom % 2) : 1'b1;
    c = 0; nb = 0; first = -1; limit = cf + 300;
    stall = rd_valid && !rd_ready;
    pd = rd_data; pl = rd_last;
    while (nb < DEPTH && c < limit) begin
      @(posedge sys_clk); #1;
      c++;
      if (stall) begin
        chk("hold valid", 32'(rd_valid), 32'd1);
        chk("hold data", 32'(rd_data), 32'(pd));
        chk("hold last", 32'(rd_last), 32'(pl));
      end
      if (rd_valid && first < 0) begin
        first = c;
        chk("read latency", 32'(c), 32'(cf + 3));
      end
      if (v.rdy == 0 && first >= 0)
        chk("no bubble", 32'(rd_valid), 32'd1);
      if (v.glitch != 0 && c == 3) begin
        arm = 1'b1;
        pre_depth = ~pre_depth;
        trig_value = ~trig_value;
      end else begin
        arm = 1'b0;
      end
      din = din_at(v.mode, c);
      rd_ready = (v.rdy != 0) ? 1'($urandom % 2) : 1'b1;
      stall = rd_valid && !rd_ready;
      pd = rd_data; pl = rd_last;
      if (rd_valid && rd_ready) begin
        chk("beat data", 32'(rd_data), 32'(exp_win[nb]));
        chk("beat last", 32'(rd_last), 32'(nb == DEPTH - 1));
        if (v.chk != 0 && nb == v.pre)
          chk("trigger sample", 32'(rd_data), 32'(v.exp_trig));
        nb++;
      end
    end
    if (nb < DEPTH) begin
      total++;
      bad++;
      $display("FAIL timeout vec %0d: beats %0d want %0d", vi, nb, DEPTH);
    end
    @(posedge sys_clk); #1;
    chk("done at end", 32'(done), 32'd1);
    chk("busy at end", 32'(busy), 32'd0);
    chk("valid at end", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{0,   8'hFF, 8'd20,  4,  0, 0, 0, 1, 8'd20};
    vecs[1] = '{999, 8'h01, 8'h01,  2,  1, 0, 0, 1, 8'h11};
    vecs[2] = '{0,   8'hFF, 8'd20,  4,  0, 1, 0, 1, 8'd20};
    vecs[3] = '{1,   8'hFF, 8'd7,   0,  0, 0, 0, 1, 8'd7};
    vecs[4] = '{0,   8'hFF, 8'd40,  15, 0, 0, 0, 1, 8'd40};
    vecs[5] = '{2,   8'h00, 8'h5A,  3,  0, 1, 0, 1, 8'd11};
    vecs[6] = '{0,   8'hFF, 8'd20,  4,  0, 0, 1, 1, 8'd20};
    for (int i = 7; i < NV; i++) begin
      vecs[i].sdiv   = int'($urandom_range(0, 3));
      vecs[i].mask   = 8'(1 << $urandom_range(0, 7))
                     | 8'(1 << $urandom_range(0, 7));
      vecs[i].value  = 8'($urandom);
      vecs[i].pre    = int'($urandom_range(0, 15));
      vecs[i].mode   = 2;
      vecs[i].rdy    = int'(i % 2);
      vecs[i].glitch = 0;
      vecs[i].chk    = 0;
      vecs[i].exp_trig = 8'h00;
    end
    for (int i = 0; i < NRND; i++) rnd[i] = 8'($urandom);

    sys_rst = 1'b1; arm = 1'b1; din = 8'h00; rd_ready = 1'b1;
    sample_div = 16'd0; trig_mask = 8'hFF; trig_value = 8'h00;
    pre_depth = 4'd0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst valid", 32'(rd_valid), 32'd0);
      chk("rst last", 32'(rd_last), 32'd0);
      chk("rst data", 32'(rd_data), 32'd0);
    end
    sys_rst = 1'b0; arm = 1'b0;
    @(posedge sys_clk); #1;
    chk("idle after rst", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) run_cap(i);

    arm_cfg(vecs[0]);
    for (int c = 1; c <= 24; c++) begin
      @(posedge sys_clk); #1;
      din = 8'(c);
    end
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst valid", 32'(rd_valid), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge sys_clk); #1;
      if (rd_valid || busy) seen = 1'b1;
    end
    chk("no beat after rst", 32'(seen), 32'd0);
    run_cap(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
